// File: rtl/prescaler_detect.sv
// Measures the period of a divided-clock input, decodes it to the 3-bit prescaler code and qualifies it with a lock flag.
// Optional macro PRESCALER_DETECT_SYNC_EN adds a 2-flop input synchronizer for asynchronous sources.
module prescaler_detect #(
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    output logic       period_valid,
    output logic [5:0] period_out,
    output logic [2:0] conf_out,
    output logic       locked,
    output logic       err
);
    localparam int unsigned CW = 6;
    localparam int unsigned MW = 3;
    localparam logic [CW-1:0] CNT_MAX = CW'(63);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_t;

    state_t        state;
    logic          sig_q;
    logic          sig_d;
    logic          edge_s;
    logic [CW-1:0] cnt;
    logic [MW-1:0] match_cnt;
    logic [2:0]    cand;
    logic [2:0]    code_c;
    logic          code_valid_c;
    logic [MW-1:0] match_next_c;

    // Input stage: a single register, or a two-flop synchronizer
`ifdef PRESCALER_DETECT_SYNC_EN
    logic sync1;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sig_q <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sig_q <= sync1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_in;
    end
`endif

    // Registered rising-edge strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d  <= 1'b0;
            edge_s <= 1'b0;
        end else begin
            sig_d  <= sig_q;
            edge_s <= sig_q & ~sig_d;
        end
    end

    // Decode of the period being captured and the resulting match count
    always_comb begin
        code_c = 3'd0;
        case (cnt)
            CW'(2):  code_c = 3'd1;
            CW'(4):  code_c = 3'd2;
            CW'(8):  code_c = 3'd3;
            CW'(16): code_c = 3'd4;
            CW'(32): code_c = 3'd5;
            default: code_c = 3'd0;
        endcase
        code_valid_c = (code_c != 3'd0);
        match_next_c = MW'(1);
        if (code_c == cand) begin
            match_next_c = (match_cnt >= LOCK_N) ? LOCK_N : MW'(match_cnt + MW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            cand         <= 3'd0;
            period_valid <= 1'b0;
            period_out   <= '0;
            conf_out     <= 3'd0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            err          <= 1'b0;

            if (edge_s)               cnt <= CW'(1);
            else if (cnt != CNT_MAX)  cnt <= CW'(cnt + CW'(1));

            case (state)
                IDLE: begin
                    if (edge_s) state <= MEASURE;
                end
                MEASURE, TRACK: begin
                    if (edge_s) begin
                        // A capture wins over a simultaneous timeout; 63 then decodes as invalid
                        state        <= TRACK;
                        period_valid <= 1'b1;
                        period_out   <= cnt;
                        if (!code_valid_c) begin
                            err       <= 1'b1;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            cand      <= 3'd0;
                        end else begin
                            cand      <= code_c;
                            match_cnt <= match_next_c;
                            if (match_next_c == LOCK_N) begin
                                locked   <= 1'b1;
                                conf_out <= code_c;
                            end else begin
                                locked   <= 1'b0;
                            end
                        end
                    end else if (cnt == CNT_MAX) begin
                        state     <= IDLE;
                        err       <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prescaler_detect.sv
// Scoreboard bench for prescaler_detect: a behavioural model predicts each output event when the input edge is driven.
module tb_prescaler_detect;
    localparam int unsigned LOCK = 2;
`ifdef PRESCALER_DETECT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig_in = 1'b0;
    logic       period_valid;
    logic [5:0] period_out;
    logic [2:0] conf_out;
    logic       locked;
    logic       err;

    prescaler_detect #(.LOCK_COUNT(LOCK)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .period_valid(period_valid), .period_out(period_out),
        .conf_out(conf_out), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         pv;
        logic [5:0] per;
        bit         er;
        bit         lk;
        logic [2:0] conf;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    int   err_seen = 0;
    bit   locked_seen = 0;

    // Behavioural model state
    int   mstate = 0;
    bit   mprev = 0;
    int   last_rise = 0;
    int   mcand = 0;
    int   mmatch = 0;
    bit   mlocked = 0;
    int   mconf = 0;
    int   mlastper = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Scoreboard monitor: compares due events, otherwise requires a quiet cycle
    always @(negedge clk) begin
        exp_t e;
        if (err === 1'b1) err_seen++;
        if (locked === 1'b1) locked_seen = 1;
        if (sbq.size() > 0 && sbq[0].cyc == ncyc) begin
            e = sbq.pop_front();
            total++;
            if (period_valid !== e.pv || period_out !== e.per || err !== e.er ||
                locked !== e.lk || conf_out !== e.conf) begin
                bad++;
                $display("FAIL event cyc=%0d got pv=%b per=%0d err=%b lk=%b conf=%0d want pv=%b per=%0d err=%b lk=%b conf=%0d",
                         ncyc, period_valid, period_out, err, locked, conf_out,
                         e.pv, e.per, e.er, e.lk, e.conf);
            end
        end else begin
            total++;
            if (period_valid !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL quiet cyc=%0d got pv=%b err=%b want pv=0 err=0", ncyc, period_valid, err);
            end
        end
    end

    // Drive one clock of stimulus and advance the model by one input sample
    task automatic drive(input bit v, input bit r);
        int   n;
        int   gap;
        int   code;
        bit   rise;
        bit   inval;
        exp_t e;
        @(negedge clk);
        #1;
        sig_in = v;
        rst    = r;
        n = ncyc + 1;
        if (r) begin
            sbq.delete();
            mstate = 0; mprev = 0; mcand = 0; mmatch = 0;
            mlocked = 0; mconf = 0; mlastper = 0;
        end else begin
            rise  = v && !mprev;
            mprev = v;
            if (mstate == 0) begin
                if (rise) begin
                    mstate = 1;
                    last_rise = n;
                end
            end else begin
                gap = n - last_rise;
                if (rise) begin
                    code = 0;
                    for (int k = 1; k <= 5; k++) if (gap == (1 << k)) code = k;
                    inval = (code == 0);
                    if (inval) begin
                        mmatch = 0; mlocked = 0; mcand = 0;
                    end else if (code == mcand) begin
                        mmatch = (mmatch + 1 > int'(LOCK)) ? int'(LOCK) : mmatch + 1;
                    end else begin
                        mcand = code; mmatch = 1; mlocked = 0;
                    end
                    if (!inval && mmatch == int'(LOCK)) begin
                        mlocked = 1;
                        mconf = code;
                    end
                    mlastper = gap;
                    e.cyc = n + LAT; e.pv = 1; e.per = 6'(gap); e.er = inval;
                    e.lk = mlocked; e.conf = 3'(mconf);
                    sbq.push_back(e);
                    last_rise = n;
                    mstate = 2;
                end else if (gap == 63) begin
                    mlocked = 0; mmatch = 0; mstate = 0;
                    e.cyc = n + LAT; e.pv = 0; e.per = 6'(mlastper); e.er = 1;
                    e.lk = 0; e.conf = 3'(mconf);
                    sbq.push_back(e);
                end
            end
        end
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) drive(1'b1, 1'b0);
            for (int i = 0; i < lo; i++) drive(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1'b1);
            total++;
            if ({period_valid, period_out, conf_out, locked, err} !== 12'd0) begin
                bad++;
                $display("FAIL reset_hold got pv=%b per=%0d conf=%0d lk=%b err=%b want all 0",
                         period_valid, period_out, conf_out, locked, err);
            end
        end
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        total++;
        if ({period_valid, period_out, conf_out, locked, err} !== 12'd0) begin
            bad++;
            $display("FAIL reset_release got pv=%b per=%0d conf=%0d lk=%b err=%b want all 0",
                     period_valid, period_out, conf_out, locked, err);
        end
    endtask

    task automatic test_lock8();
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        wave(4, 4, 4);
        total++;
        if (locked !== 1'b1 || conf_out !== 3'd3 || period_out !== 6'd8) begin
            bad++;
            $display("FAIL lock8 got lk=%b conf=%0d per=%0d want lk=1 conf=3 per=8", locked, conf_out, period_out);
        end
    endtask

    task automatic test_rate_change();
        wave(16, 16, 2);
        total++;
        if (locked !== 1'b0 || conf_out !== 3'd3 || period_out !== 6'd32) begin
            bad++;
            $display("FAIL rate_first32 got lk=%b conf=%0d per=%0d want lk=0 conf=3 per=32", locked, conf_out, period_out);
        end
        wave(16, 16, 2);
        total++;
        if (locked !== 1'b1 || conf_out !== 3'd5) begin
            bad++;
            $display("FAIL rate_relock got lk=%b conf=%0d want lk=1 conf=5", locked, conf_out);
        end
    endtask

    task automatic test_invalid();
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        err_seen = 0;
        locked_seen = 0;
        wave(3, 3, 8);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
        total++;
        if (err_seen != 7 || locked_seen != 1'b0) begin
            bad++;
            $display("FAIL invalid6 got errs=%0d locked_seen=%b want errs=7 locked_seen=0", err_seen, locked_seen);
        end
    endtask

    task automatic test_timeout();
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        wave(1, 1, 4);
        total++;
        if (locked !== 1'b1 || conf_out !== 3'd1) begin
            bad++;
            $display("FAIL timeout_prelock got lk=%b conf=%0d want lk=1 conf=1", locked, conf_out);
        end
        err_seen = 0;
        for (int i = 0; i < 80; i++) drive(1'b0, 1'b0);
        total++;
        if (err_seen != 1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err got errs=%0d lk=%b want errs=1 lk=0", err_seen, locked);
        end
        wave(1, 1, 3);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
        total++;
        if (locked !== 1'b1 || conf_out !== 3'd1) begin
            bad++;
            $display("FAIL timeout_relock got lk=%b conf=%0d want lk=1 conf=1", locked, conf_out);
        end
    endtask

    task automatic test_latency_and_reset();
        int  n1;
        int  seen;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        n1 = ncyc + 1;
        seen = -1;
        for (int i = 0; i < 10 && seen < 0; i++) begin
            drive(1'b0, 1'b0);
            if (period_valid === 1'b1) seen = ncyc;
        end
        total++;
        if (seen != n1 + LAT) begin
            bad++;
            $display("FAIL latency got cyc=%0d want cyc=%0d", seen, n1 + LAT);
        end
        wave(1, 1, 3);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
        total++;
        if (locked !== 1'b1 || conf_out !== 3'd1) begin
            bad++;
            $display("FAIL midlock_pre got lk=%b conf=%0d want lk=1 conf=1", locked, conf_out);
        end
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        total++;
        if (locked !== 1'b0 || conf_out !== 3'd0) begin
            bad++;
            $display("FAIL midlock_reset got lk=%b conf=%0d want lk=0 conf=0", locked, conf_out);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_lock8();
        test_rate_change();
        test_invalid();
        test_timeout();
        test_latency_and_reset();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
